dispatcher_fixed: RTL
=====================

Name: dispatcher_fixed

Overview:
- 1-to-N stream dispatcher; the counterpart of the N-to-1 fixed-priority arbiter.
- Takes a single valid/ready input stream and hands each beat to one of N consumers, e.g. fanning instructions out to parallel engines.
- Target selection is fixed-priority: the beat goes to the lowest-index output whose queue is not full.
- Each output has a small registered FIFO, so no combinational path runs from any out_ready to in_ready.

Parameters:
- DWIDTH, 8, data width of each beat.
- N, 2, number of outputs (N >= 1).
- DEPTH, 2, entries per output queue (DEPTH >= 1; need not be a power of 2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_data  input  DWIDTH  input beat payload.
- in_ready  output  1  dispatcher accepts the beat this cycle.
- out_valid  output  1 x [N-1:0] (unpacked)  queue i has a head beat.
- out_data  output  [DWIDTH-1:0] x [N-1:0] (unpacked)  head payload of queue i.
- out_ready  input  1 x [N-1:0] (unpacked)  consumer i takes the head.
- idle  output  1  all queues empty.

Behaviour:
- Reset:
  - While rst is high, all queue counts, read pointers and write pointers are 0.
  - out_valid[i]=0 for all i; idle=1.
  - in_ready evaluates to 1, because all queues are not full; no beat is accepted while rst is high.
  - out_data is don't-care, but must not be X-propagating into out_valid.
- Per-queue state: count[i] (0..DEPTH), write pointer, read pointer.
  - full[i] = (count[i]==DEPTH); empty[i] = (count[i]==0).
- Target selection (combinational, from registered state only):
  - sel = lowest i with full[i]==0.
  - in_ready = OR of ~full[i]; no dependency on out_ready or in_valid.
- Push: on in_valid & in_ready, in_data is written to queue[sel] at its write pointer.
  - Write pointer wraps DEPTH-1 -> 0.
  - Exactly one queue is written per accepted beat.
- Pop:
  - out_valid[i] = ~empty[i].
  - out_data[i] = entry at the read pointer (registered storage, no bypass).
  - On out_valid[i] & out_ready[i], the read pointer advances and wraps DEPTH-1 -> 0.
- Count update per queue per cycle: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- A full queue is ineligible for push even if it pops in the same cycle; the freed slot becomes eligible next cycle.
- Latency: a beat accepted in cycle t appears on out_valid/out_data of its queue in cycle t+1 at the earliest. There is no same-cycle bypass.
- Ordering:
  - Per-queue order is FIFO.
  - Global order across outputs is not preserved.
- out_valid[i] must not drop and out_data[i] must not change while out_ready[i] is low (AXI-style stability).
- idle = AND of empty[i], registered-state derived.
- Backpressure: when all queues are full, in_ready=0 and the input must hold its beat; the dispatcher takes no action.
- Reset mid-operation: all queued beats are discarded immediately (asynchronous); outputs return to their reset values the same instant.
- N=1 degenerates to a plain DEPTH-entry FIFO.

Test Plan:
- Reset defaults (N=2, DEPTH=2): assert rst -> out_valid={0,0}, idle=1, in_ready=1; with in_valid=1 held during reset, no beat is stored after release.
- Fixed-priority fill (N=2, DEPTH=2), all out_ready=0: push 0x11,0x22,0x33,0x44 on consecutive cycles.
  - 0x11,0x22 go to q0; 0x33,0x44 go to q1.
  - in_ready drops to 0 after the 4th accept.
  - out_data[0]=0x11 and out_data[1]=0x33, stable while held.
- Latency and drain:
  - Empty dispatcher, push 0xA5 at cycle t -> out_valid[0]=1 at t+1 with out_data[0]=0xA5.
  - out_ready[0]=1 at t+1 -> out_valid[0]=0 and idle=1 at t+2.
- Full-and-pop same cycle: q0 full (0x11,0x22), q1 empty, out_ready[0]=1, push 0x55.
  - 0x55 goes to q1; q0 count becomes 1.
  - On the next push with q0 not full, the beat goes to q0.
- Wrap-around (N=1, DEPTH=3): stream 0x00..0x09 with out_ready toggling 1,0,1,0,... -> output order is exactly 0x00..0x09 with no loss or duplication.
- Reset mid-stream: q0 holds 2 beats and q1 holds 1; pulse rst asynchronously between clock edges -> out_valid={0,0} immediately, idle=1; a fresh push after release lands in q0.

Source files
------------

// File: rtl/dispatcher_fixed.sv
// 1-to-N stream dispatcher: each accepted beat goes to the lowest-index output
// queue with a free slot. Every output is fed from its own registered FIFO.
module dispatcher_fixed #(
   parameter int DWIDTH = 8,
   parameter int N      = 2,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DWIDTH-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid [N],
   output logic [DWIDTH-1:0] out_data  [N],
   input  logic              out_ready [N],
   output logic              idle
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

   logic [CW-1:0]     count  [N];
   logic [PW-1:0]     wr_ptr [N];
   logic [PW-1:0]     rd_ptr [N];
   logic [DWIDTH-1:0] mem    [N][DEPTH];

   logic [N-1:0] full;
   logic [N-1:0] empty;
   logic [N-1:0] push;
   logic [N-1:0] pop;
   logic         any_free;

   // Selection looks only at registered counts, so in_ready never sees out_ready.
   always_comb begin
      full     = '0;
      empty    = '0;
      push     = '0;
      pop      = '0;
      any_free = 1'b0;
      for (int i = 0; i < N; i++) begin
         full[i]  = (count[i] == CNT_FULL);
         empty[i] = (count[i] == '0);
         pop[i]   = ~empty[i] & out_ready[i];
         if (!full[i] && !any_free) begin
            push[i]  = in_valid;
            any_free = 1'b1;
         end
      end
   end

   assign in_ready = any_free;
   assign idle     = &empty;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         out_valid[i] = ~empty[i];
         out_data[i]  = mem[i][rd_ptr[i]];
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (push[i] && !rst) mem[i][wr_ptr[i]] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            count[i]  <= '0;
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (push[i])
               wr_ptr[i] <= (wr_ptr[i] == PTR_LAST) ? '0 : wr_ptr[i] + PW'(1);
            if (pop[i])
               rd_ptr[i] <= (rd_ptr[i] == PTR_LAST) ? '0 : rd_ptr[i] + PW'(1);
            case ({push[i], pop[i]})
               2'b10:   count[i] <= count[i] + CW'(1);
               2'b01:   count[i] <= count[i] - CW'(1);
               default: count[i] <= count[i];
            endcase
         end
      end
   end

endmodule
